// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
// The slave modport is the responder side; master is the memory-stage side.
interface dmem_responder_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [XLEN-1:0] req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            req_we_i;
    logic [2:0]      req_funct3_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_err_o;
    logic            busy_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_funct3_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_funct3_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, WAIT_CYCLES wait states,
// byte-lane word array, raw aligned word returned (extension is done by the LSU).

// One byte lane of the word array; contents are intentionally not reset.
module dmem_lane #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dmem_responder_if.slave    bus
);
    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam int NUM_LANES = XLEN / 8;
    localparam int LANE_W    = $clog2(NUM_LANES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic            we;
        logic [2:0]      funct3;
    } req_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    req_t            req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [1:0]                      size;
    logic [LANE_W-1:0]               lane;
    logic [IDX_W-1:0]                widx;
    logic                            out_of_range, misaligned, illegal, access_err;
    logic [NUM_LANES-1:0]            be, lane_we;
    logic [NUM_LANES-1:0][7:0]       lane_wdata, lane_rdata;

    assign size = req_q.funct3[1:0];
    assign lane = req_q.addr[LANE_W-1:0];
    assign widx = req_q.addr[IDX_W+1:2];

    // Everything above the word-index field must be zero to hit the array.
    assign out_of_range = |(req_q.addr >> (IDX_W + 2));
    assign misaligned   = (size == 2'b01 && req_q.addr[0]) ||
                          (size == 2'b10 && req_q.addr[1:0] != 2'b00);
    assign illegal      = (size == 2'b11) || (req_q.we && req_q.funct3[2]);
    assign access_err   = out_of_range || misaligned || illegal;

    // Store data is right-aligned, so byte/half data is replicated across lanes
    // and the byte enables pick which lanes actually take it.
    always_comb begin
        be         = '0;
        lane_wdata = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            case (size)
                2'b00: begin
                    be[l]         = (LANE_W'(l) == lane);
                    lane_wdata[l] = req_q.wdata[7:0];
                end
                2'b01: begin
                    be[l]         = ((LANE_W'(l) >> 1) == (lane >> 1));
                    lane_wdata[l] = req_q.wdata[8*(l%2) +: 8];
                end
                default: begin
                    be[l]         = 1'b1;
                    lane_wdata[l] = req_q.wdata[8*l +: 8];
                end
            endcase
        end
    end

    assign lane_we = (state_q == S_ACCESS && req_q.we && !access_err) ? be : '0;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dmem_lane #(.DEPTH(DEPTH_WORDS)) u_lane (
            .clk   (clk_i),
            .we    (lane_we[g]),
            .idx   (widx),
            .wdata (lane_wdata[g]),
            .rdata (lane_rdata[g])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    req_d.addr   = bus.req_addr_i;
                    req_d.wdata  = bus.req_wdata_i;
                    req_d.we     = bus.req_we_i;
                    req_d.funct3 = bus.req_funct3_i;
                    cnt_d        = 4'(WAIT_CYCLES);
                    state_d      = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                err_d   = access_err;
                rdata_d = (access_err || req_q.we) ? '0 : XLEN'(lane_rdata);
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready_o = (state_q == S_IDLE);
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.rsp_valid_o = (state_q == S_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder. It serves load/store requests from the multicycle core's memory stage.
- Replaces the single-cycle data_memory when the bus needs wait states.
- Accepts one request at a time and inserts a configurable number of wait cycles.
- Performs the word-array access with byte-lane enables derived from funct3. Returns the raw aligned word plus an error flag; load_store_unit does sign/zero extension.

Parameters:
- XLEN, 32, data/address width.
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- WAIT_CYCLES, 2, wait cycles between accept and access (0..15).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  responder can accept a request.
- req_addr_i  in  XLEN  byte address.
- req_wdata_i  in  XLEN  store data, right-aligned.
- req_we_i  in  1  1=store, 0=load.
- req_funct3_i  in  3  RISC-V funct3 of the load/store.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  initiator accepts response.
- rsp_rdata_o  out  XLEN  aligned word read (0 for stores and errors).
- rsp_err_o  out  1  misaligned, out-of-range or illegal funct3.
- busy_o  out  1  request in flight (state != IDLE).

Behaviour:
- Reset (asynchronous):
  - state=IDLE, wait counter=0, latched request cleared.
  - Outputs: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, latch addr/wdata/we/funct3 and load counter=WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
  - WAIT: counter decrements each cycle. Go to ACCESS when counter reaches 1.
  - ACCESS (one cycle): run the error check, then the write, or the read into rsp_rdata_o. Set rsp_err_o. Go to RESP.
  - RESP: rsp_valid_o=1. rsp_rdata_o and rsp_err_o are held stable until rsp_valid_o&&rsp_ready_i, then go to IDLE. A new request can be accepted no earlier than the following cycle.
- Latency:
  - Accept at edge N gives rsp_valid_o high after edge N+WAIT_CYCLES+1.
  - Throughput is one request per WAIT_CYCLES+3 cycles when rsp_ready_i=1.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Error checks (size = funct3[1:0]):
  - Out of range: any addr bit above log2(DEPTH_WORDS)+1 is set.
  - size 00 (byte) is always aligned.
  - size 01 (half) is misaligned when addr[0]=1.
  - size 10 (word) is misaligned when addr[1:0]!=0.
  - size 11 is illegal.
  - Stores with funct3[2]=1 are illegal.
  - On any error: no array write, rsp_rdata_o=0, rsp_err_o=1.
- Stores:
  - SB writes wdata[7:0] into byte lane addr[1:0].
  - SH writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - SW writes the full word.
  - Other lanes are unchanged. rsp_rdata_o=0.
- Loads: rsp_rdata_o is the full word at the word index, unshifted. Lane selection and extension are the LSU's job.
- Request inputs are ignored while state!=IDLE; changes on the inputs have no effect.
- Reset mid-operation: if asserted in WAIT, the latched store is discarded and the array is unchanged. If asserted in RESP, the write is already committed and the response is dropped.
- A read after a write to the same word sees the new data, since the write completes in ACCESS before the next request can be accepted.

Test Plan:
- Reset asserted then released -> req_ready_o=1, busy_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- SW 0xDEADBEEF @0x10, then LW @0x10, WAIT_CYCLES=2, rsp_ready_i=1 -> each rsp_valid_o rises 3 cycles after accept. LW returns 0xDEADBEEF with rsp_err_o=0.
- After the SW: SB 0x55 @0x12, then SH 0x1234 @0x10, then LW @0x10 -> 0xDE551234.
- SW @0x12 -> rsp_err_o=1, rsp_rdata_o=0, word 0x10 unchanged. LW @(DEPTH_WORDS*4) -> rsp_err_o=1. Store with funct3=3'b100 -> rsp_err_o=1.
- rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o and rsp_rdata_o stable, req_ready_o=0. A req_valid_i pulse in that window is not accepted.
- SW 0x0BADF00D @0x20, then rst_i pulsed during WAIT, then LW @0x20 -> returns the pre-store value, state IDLE immediately on rst_i.
